// File: rtl/crc_pkg.sv
// Shared parameters and state encoding for the CRC receive controller.
package crc_pkg;

    localparam int DATA_W    = 64;
    localparam int CRC_W     = 3;
    localparam int FRAME_W   = DATA_W + CRC_W;
    localparam int MAX_RETRY = 3;
    localparam int CNT_W     = 7;
    localparam int RETRY_W   = $clog2(MAX_RETRY + 1);
    localparam int ERR_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/crc_rx_ctrl_if.sv
// Bit-sampler input, result handshake and status pulses of the CRC receive controller.
interface crc_rx_ctrl_if;
    import crc_pkg::*;

    logic [CRC_W:0]   poly;
    logic             bit_in;
    logic             bit_valid;
    logic             frame_start;
    logic [DATA_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             crc_ok;
    logic [CRC_W-1:0] syndrome;
    logic             nack;
    logic             drop;
    logic             overrun;
    logic [ERR_W-1:0] err_count;

    // master is the controller; slave is the PHY/sink side that feeds bits and consumes results
    modport master (
        input  poly, bit_in, bit_valid, frame_start, out_ready,
        output out_data, out_valid, crc_ok, syndrome, nack, drop, overrun, err_count
    );

    modport slave (
        output poly, bit_in, bit_valid, frame_start, out_ready,
        input  out_data, out_valid, crc_ok, syndrome, nack, drop, overrun, err_count
    );

endinterface

// File: rtl/crc_serial_div.sv
// Bit-serial polynomial divider: one remainder step per enabled bit, MSB first.
module crc_serial_div
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load_poly,
    input  logic             i_shift_en,
    input  logic             i_bit,
    input  logic [CRC_W:0]   i_poly,
    output logic [CRC_W-1:0] o_rem,
    output logic [CRC_W-1:0] o_rem_next
);

    localparam logic [CRC_W:0] POLY_TOP = {1'b1, {CRC_W{1'b0}}};

    logic [CRC_W:0]   r_poly;
    logic [CRC_W-1:0] r_rem;
    logic [CRC_W:0]   w_poly;
    logic [CRC_W-1:0] w_base;
    logic             w_fb;

    // The leading generator term is always present, whatever the input says.
    assign w_poly     = i_load_poly ? (i_poly | POLY_TOP) : r_poly;
    assign w_base     = i_clear ? '0 : r_rem;
    assign w_fb       = w_base[CRC_W-1] & w_poly[CRC_W];
    assign o_rem_next = {w_base[CRC_W-2:0], i_bit} ^ (w_fb ? w_poly[CRC_W-1:0] : '0);
    assign o_rem      = r_rem;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_poly <= '0;
        end else begin
            if (i_shift_en) begin
                r_rem <= o_rem_next;
            end else if (i_clear) begin
                r_rem <= '0;
            end
            if (i_load_poly) begin
                r_poly <= w_poly;
            end
        end
    end

endmodule

// File: rtl/crc_rx_ctrl.sv
// Receive frame controller: deserialises 64+3-bit frames, checks the CRC, drives NACK/retry status.
module crc_rx_ctrl
    import crc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    crc_rx_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_data;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_nack;
    logic               r_drop;
    logic               r_overrun;
    logic               w_start;
    logic               w_shift;
    logic               w_last;
    logic               w_overrun;
    logic               w_frame_bit;
    logic [CRC_W-1:0]   w_rem;
    logic [CRC_W-1:0]   w_rem_next;

    assign w_frame_bit = bus.bit_valid && bus.frame_start;
    assign w_last      = w_shift && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_overrun    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_frame_bit) begin
                    w_start      = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_frame_bit) begin
                    w_start   = 1'b1;
                    w_overrun = 1'b1;
                end else if (bus.bit_valid) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_next_state = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                    if (w_frame_bit) begin
                        w_start      = 1'b1;
                        w_next_state = ST_SHIFT;
                    end
                end else if (w_frame_bit) begin
                    w_overrun = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Only the first DATA_W bits are kept; the CRC bits live on solely in the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_data    <= '0;
        end else if (w_start) begin
            r_bit_cnt <= CNT_W'(1);
            r_data    <= {{(DATA_W-1){1'b0}}, bus.bit_in};
        end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt < CNT_W'(DATA_W)) begin
                r_data <= {r_data[DATA_W-2:0], bus.bit_in};
            end
        end
    end

    // Retry bookkeeping uses the remainder that includes the final bit being sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retry_cnt <= '0;
            r_err_count <= '0;
            r_nack      <= 1'b0;
            r_drop      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_nack    <= 1'b0;
            r_drop    <= 1'b0;
            r_overrun <= w_overrun;
            if (w_last) begin
                if (w_rem_next != '0) begin
                    r_nack <= 1'b1;
                    if (r_err_count != '1) begin
                        r_err_count <= r_err_count + ERR_W'(1);
                    end
                    if (r_retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
                        r_drop      <= 1'b1;
                        r_retry_cnt <= '0;
                    end else begin
                        r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                    end
                end else begin
                    r_retry_cnt <= '0;
                end
            end
        end
    end

    crc_serial_div u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_start),
        .i_load_poly (w_start),
        .i_shift_en  (w_start | w_shift),
        .i_bit       (bus.bit_in),
        .i_poly      (bus.poly),
        .o_rem       (w_rem),
        .o_rem_next  (w_rem_next)
    );

    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.out_data  = r_data;
    assign bus.crc_ok    = (r_state == ST_HOLD) && (w_rem == '0);
    assign bus.syndrome  = w_rem;
    assign bus.nack      = r_nack;
    assign bus.drop      = r_drop;
    assign bus.overrun   = r_overrun;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_crc_rx_ctrl.sv
// Randomised self-checking bench for crc_rx_ctrl against a long-division reference model.
module tb_crc_rx_ctrl;
    import crc_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic        ok;
        logic [2:0]  syn;
    } result_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_rx_ctrl_if bus();

    crc_rx_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int        n_checks = 0;
    int        n_pass = 0;
    result_t   exp_q[$];
    int        exp_retry = 0;
    int        exp_err = 0;
    int        exp_results = 0;
    int        ovr_seen = 0;
    int        hs_seen = 0;
    logic [3:0] cur_poly = 4'b1011;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Plain long division of the whole frame by the generator (top bit forced to 1).
    function automatic logic [2:0] ref_rem(input logic [66:0] f, input logic [3:0] p);
        logic [66:0] r;
        logic [66:0] d;
        r = f;
        for (int i = 66; i >= 3; i--) begin
            if (r[i]) begin
                d = {63'd0, (p | 4'b1000)} << (i - 3);
                r = r ^ d;
            end
        end
        return r[2:0];
    endfunction

    function automatic logic [66:0] good_frame(input logic [63:0] d, input logic [3:0] p);
        return {d, ref_rem({d, 3'b000}, p)};
    endfunction

    function automatic logic [66:0] corrupt(input logic [66:0] f);
        logic [66:0] one;
        one = 67'd1;
        return f ^ (one << $urandom_range(66));
    endfunction

    // Scoreboard: every completed handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.overrun) ovr_seen++;
            if (bus.out_valid && bus.out_ready) begin
                hs_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(bus.out_valid), 64'd0);
                end else begin
                    result_t e;
                    e = exp_q.pop_front();
                    check("hs_data", bus.out_data, e.data);
                    check("hs_crc_ok", 64'(bus.crc_ok), 64'(e.ok));
                    check("hs_syndrome", 64'(bus.syndrome), 64'(e.syn));
                end
            end
        end
    end

    task automatic tick(input logic bv, input logic b, input logic fs, input logic rdy);
        bus.bit_valid   = bv;
        bus.bit_in      = b;
        bus.frame_start = fs;
        bus.out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    // Sends the first n_bits of frame f; full frames are checked on the first out_valid cycle.
    task automatic send_frame(input logic [66:0] f, input int gap_pct, input int n_bits);
        result_t r;
        logic    exp_nack;
        logic    exp_drop;
        bus.poly = cur_poly;
        tick(1'b1, f[66], 1'b1, 1'b1);
        bus.poly = 4'($urandom);
        for (int i = 65; i >= 67 - n_bits; i--) begin
            while ($urandom_range(99) < gap_pct) tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            if (i == 0) check("valid_before_last", 64'(bus.out_valid), 64'd0);
            tick(1'b1, f[i], 1'b0, 1'($urandom));
        end
        if (n_bits == 67) begin
            r.data   = f[66:3];
            r.syn    = ref_rem(f, cur_poly);
            r.ok     = (r.syn == 3'b000);
            exp_nack = !r.ok;
            exp_drop = 1'b0;
            if (r.ok) begin
                exp_retry = 0;
            end else begin
                if (exp_err < 255) exp_err++;
                exp_retry++;
                if (exp_retry == MAX_RETRY) begin
                    exp_drop  = 1'b1;
                    exp_retry = 0;
                end
            end
            check("out_valid", 64'(bus.out_valid), 64'd1);
            check("out_data", bus.out_data, r.data);
            check("crc_ok", 64'(bus.crc_ok), 64'(r.ok));
            check("syndrome", 64'(bus.syndrome), 64'(r.syn));
            check("nack", 64'(bus.nack), 64'(exp_nack));
            check("drop", 64'(bus.drop), 64'(exp_drop));
            check("err_count", 64'(bus.err_count), 64'(exp_err));
            exp_q.push_back(r);
            exp_results++;
        end
    endtask

    task automatic release_out(input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) tick(1'b0, 1'($urandom), 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("valid_after_hs", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic do_reset();
        bus.bit_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.out_ready   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        exp_retry = 0;
        exp_err   = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          c0;
        int          o0;
        logic [66:0] f;

        bus.poly = cur_poly;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_crc_ok", 64'(bus.crc_ok), 64'd0);
        check("rst_syndrome", 64'(bus.syndrome), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_pulses", 64'({bus.nack, bus.drop, bus.overrun}), 64'd0);
        check("rst_err_count", 64'(bus.err_count), 64'd0);

        // Good frame: minimum latency and clean result.
        c0 = cyc;
        send_frame({64'h1, 3'b011}, 0, 67);
        check("latency", 64'(cyc - c0), 64'd67);
        release_out(0);

        // Single corrupted frame, expected syndrome 001.
        send_frame({64'h1, 3'b010}, 0, 67);
        check("syndrome_001", 64'(bus.syndrome), 64'd1);
        release_out(0);
        send_frame(good_frame(64'h1234_5678_9abc_def0, cur_poly), 20, 67);
        release_out(1);

        // Three consecutive failures drop on the third, then a good frame recovers.
        for (int k = 0; k < 3; k++) begin
            send_frame(corrupt(good_frame({$urandom, $urandom}, cur_poly)), 10, 67);
            release_out(0);
        end
        send_frame(good_frame({$urandom, $urandom}, cur_poly), 10, 67);
        release_out(0);

        // Restart mid-frame at bit 20.
        o0 = ovr_seen;
        send_frame({$urandom, $urandom, 3'b101}, 0, 20);
        send_frame(good_frame({$urandom, $urandom}, cur_poly), 0, 67);
        release_out(0);
        check("overrun_restart", 64'(ovr_seen - o0), 64'd1);

        // Stall in HOLD while a new frame start arrives and is dropped.
        f = good_frame({$urandom, $urandom}, cur_poly);
        send_frame(f, 0, 67);
        o0 = ovr_seen;
        for (int i = 0; i < 10; i++) begin
            tick(i == 4, 1'($urandom), i == 4, 1'b0);
            check("hold_data", bus.out_data, f[66:3]);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
        end
        release_out(0);
        check("overrun_hold", 64'(ovr_seen - o0), 64'd1);

        // Reset at bit 40 discards the partial frame.
        send_frame(corrupt(good_frame({$urandom, $urandom}, cur_poly)), 0, 40);
        do_reset();
        check("reset_err_count", 64'(bus.err_count), 64'd0);
        check("reset_valid", 64'(bus.out_valid), 64'd0);
        send_frame(good_frame({$urandom, $urandom}, cur_poly), 0, 67);
        release_out(0);

        // Back-to-back frames with out_ready high: zero bubble.
        c0 = cyc;
        for (int k = 0; k < 4; k++) send_frame(good_frame({$urandom, $urandom}, cur_poly), 0, 67);
        release_out(0);
        check("b2b_cycles", 64'(cyc - c0), 64'(4 * 67 + 1));

        // Random polynomials, gaps, corruption and release timing.
        for (int k = 0; k < 40; k++) begin
            cur_poly = 4'($urandom);
            f = good_frame({$urandom, $urandom}, cur_poly);
            if ($urandom_range(99) < 40) f = corrupt(f);
            send_frame(f, 30, 67);
            if ($urandom_range(1) == 1) release_out($urandom_range(3));
        end
        release_out(0);

        // Enough failures to saturate err_count.
        cur_poly = 4'b1011;
        for (int k = 0; k < 250; k++) send_frame(corrupt(good_frame({$urandom, $urandom}, cur_poly)), 0, 67);
        release_out(0);
        check("err_saturated", 64'(bus.err_count), 64'd255);

        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
        check("pending_results", 64'(exp_q.size()), 64'd0);
        check("handshake_count", 64'(hs_seen), 64'(exp_results));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
